// File: rtl/condicionador_jogada.sv
// Button conditioner for the game: two-flop synchronizer, press/release debounce,
// multi-button rejection and one strobe per physical press.
module condicionador_jogada #(
    parameter int unsigned N_BOTOES        = 4,
    parameter int unsigned DEBOUNCE_CICLOS = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                limpa,
    input  logic [N_BOTOES-1:0] botoes,
    output logic                jogada,
    output logic [N_BOTOES-1:0] jogada_valor,
    output logic                multipla,
    output logic [2:0]          db_estado_cond
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [CW-1:0] CONT_ALVO = CW'(DEBOUNCE_CICLOS - 1);
    localparam logic [CW-1:0] CONT_MAX  = CW'(DEBOUNCE_CICLOS);

    typedef enum logic [2:0] {
        OCIOSO         = 3'd0,
        FILTRA_PRESSAO = 3'd1,
        EMITE          = 3'd2,
        REJEITA        = 3'd3,
        ESPERA_SOLTURA = 3'd4,
        FILTRA_SOLTURA = 3'd5
    } estado_t;

    estado_t             estado_q, estado_d;
    logic [N_BOTOES-1:0] sinc1_q, botoes_s_q;
    logic [N_BOTOES-1:0] candidato_q, candidato_d;
    logic [N_BOTOES-1:0] valor_q, valor_d;
    logic [CW-1:0]       cont_q, cont_d;
    logic                jogada_q, multipla_q;
    logic [CW-1:0]       cont_inc;
    logic                um_quente;

    // Saturating count so a large DEBOUNCE_CICLOS never wraps back into range.
    assign cont_inc  = (cont_q == CONT_MAX) ? cont_q : cont_q + CW'(1);
    assign um_quente = (candidato_q != '0) &&
                       ((candidato_q & (candidato_q - N_BOTOES'(1))) == '0);

    always_comb begin
        estado_d    = estado_q;
        cont_d      = cont_q;
        candidato_d = candidato_q;
        valor_d     = valor_q;
        case (estado_q)
            OCIOSO: begin
                if (botoes_s_q != '0) begin
                    candidato_d = botoes_s_q;
                    cont_d      = '0;
                    estado_d    = FILTRA_PRESSAO;
                end
            end
            FILTRA_PRESSAO: begin
                if (botoes_s_q == '0) begin
                    estado_d = OCIOSO;
                end else if (botoes_s_q != candidato_q) begin
                    candidato_d = botoes_s_q;
                    cont_d      = '0;
                end else if (cont_q == CONT_ALVO) begin
                    if (um_quente) begin
                        estado_d = EMITE;
                        valor_d  = candidato_q;
                    end else begin
                        estado_d = REJEITA;
                    end
                end else begin
                    cont_d = cont_inc;
                end
            end
            EMITE, REJEITA: estado_d = ESPERA_SOLTURA;
            ESPERA_SOLTURA: begin
                if (botoes_s_q == '0) begin
                    cont_d   = '0;
                    estado_d = FILTRA_SOLTURA;
                end
            end
            FILTRA_SOLTURA: begin
                if (botoes_s_q != '0) begin
                    estado_d = ESPERA_SOLTURA;
                end else if (cont_q == CONT_ALVO) begin
                    estado_d = OCIOSO;
                end else begin
                    cont_d = cont_inc;
                end
            end
            default: estado_d = ESPERA_SOLTURA;
        endcase
        // A clear from the control unit overrides every transition, EMITE included.
        if (limpa) begin
            estado_d    = ESPERA_SOLTURA;
            cont_d      = '0;
            candidato_d = '0;
            valor_d     = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sinc1_q     <= '0;
            botoes_s_q  <= '0;
            estado_q    <= ESPERA_SOLTURA;
            cont_q      <= '0;
            candidato_q <= '0;
            valor_q     <= '0;
            jogada_q    <= 1'b0;
            multipla_q  <= 1'b0;
        end else begin
            sinc1_q     <= botoes;
            botoes_s_q  <= sinc1_q;
            estado_q    <= estado_d;
            cont_q      <= cont_d;
            candidato_q <= candidato_d;
            valor_q     <= valor_d;
            jogada_q    <= (estado_d == EMITE);
            multipla_q  <= (estado_d == REJEITA);
        end
    end

    assign jogada         = jogada_q;
    assign multipla       = multipla_q;
    assign jogada_valor   = valor_q;
    assign db_estado_cond = estado_q;

endmodule
